// File: rtl/m_dram_arbiter.sv
// Shares one DRAM port among PTW/CPU/DMA: fixed PTW > CPU > DMA, PTW lock with idle watchdog, one access in flight.
// dram_req one cycle after the grant cycle, done one cycle after ack; stalls in ISSUE while i_dram_busy. ARB_RR_EN: CPU/DMA round-robin.
module m_dram_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 15
) (
    input  logic                CLK,
    input  logic                RST_X,
    input  logic [2:0]          i_req,
    input  logic [2:0]          i_we,
    input  logic [3*ADDR_W-1:0] i_addr,
    input  logic [3*DATA_W-1:0] i_wdata,
    input  logic                i_ptw_lock,
    output logic [2:0]          o_gnt,
    output logic [2:0]          o_done,
    output logic [DATA_W-1:0]   o_rdata,
    output logic                o_lock_err,
    output logic                o_dram_req,
    output logic                o_dram_we,
    output logic [ADDR_W-1:0]   o_dram_addr,
    output logic [DATA_W-1:0]   o_dram_wdata,
    input  logic                i_dram_busy,
    input  logic                i_dram_ack,
    input  logic [DATA_W-1:0]   i_dram_rdata
);

    localparam int WD_W = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [2:0]          owner_q, owner_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                lock_q, lock_d;
    logic [WD_W-1:0]     wd_q, wd_d;
`ifdef ARB_RR_EN
    logic                rr_q, rr_d;     // 1: DMA wins the next CPU/DMA tie
`endif

    logic                wd_fire;
    logic                lock_eff;
    logic [2:0]          elig;
    logic [2:0]          win;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    // A watchdog expiry releases the lock in the same cycle so a waiting master is granted at once.
    assign wd_fire  = (state_q == S_IDLE) && lock_q && !i_req[0] && (wd_q == WD_W'(LOCK_MAX - 1));
    assign lock_eff = lock_q && i_ptw_lock && !wd_fire;
    assign elig     = lock_eff ? {2'b00, i_req[0]} : i_req;

    always_comb begin
        win = 3'b000;
        if (elig[0]) begin
            win = 3'b001;
        end else if (elig[1] && elig[2]) begin
`ifdef ARB_RR_EN
            win = rr_q ? 3'b100 : 3'b010;
`else
            win = 3'b010;
`endif
        end else if (elig[1]) begin
            win = 3'b010;
        end else if (elig[2]) begin
            win = 3'b100;
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < 3; k++) begin
            if (win[k]) begin
                sel_we    = i_we[k];
                sel_addr  = i_addr[k*ADDR_W +: ADDR_W];
                sel_wdata = i_wdata[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        lock_d  = lock_q;
        wd_d    = wd_q;
`ifdef ARB_RR_EN
        rr_d    = rr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|win) begin
                    state_d = S_ISSUE;
                    owner_d = win;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
`ifdef ARB_RR_EN
                    if (win[1]) rr_d = 1'b1;
                    if (win[2]) rr_d = 1'b0;
`endif
                end
            end
            S_ISSUE: begin
                if (!i_dram_busy) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_dram_ack) begin
                    state_d = S_DONE;
                    if (!we_q) rdata_d = i_dram_rdata;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                owner_d = 3'b000;
                if (owner_q[0] && i_ptw_lock) lock_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (!i_ptw_lock || wd_fire) lock_d = 1'b0;

        if (!lock_d) begin
            wd_d = '0;
        end else if (state_q == S_IDLE && win[0]) begin
            wd_d = '0;
        end else if (state_q == S_IDLE && lock_q && !i_req[0]) begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q <= S_IDLE;
            owner_q <= 3'b000;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            lock_q  <= 1'b0;
            wd_q    <= '0;
`ifdef ARB_RR_EN
            rr_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            lock_q  <= lock_d;
            wd_q    <= wd_d;
`ifdef ARB_RR_EN
            rr_q    <= rr_d;
`endif
        end
    end

    assign o_gnt        = (state_q == S_ISSUE || state_q == S_WAIT) ? owner_q : 3'b000;
    assign o_done       = (state_q == S_DONE) ? owner_q : 3'b000;
    assign o_rdata      = rdata_q;
    assign o_lock_err   = wd_fire;
    assign o_dram_req   = (state_q == S_ISSUE) && !i_dram_busy;
    assign o_dram_we    = we_q;
    assign o_dram_addr  = addr_q;
    assign o_dram_wdata = wdata_q;

endmodule
